roic_line_seq: RTL and testbench

Frame-level line sequencer for the TI ROIC path. It sits directly upstream of `sync_gen` and drives its `sync_trigger` input. On a start command it emits one trigger per line period for a programmable number of dummy (flush) lines followed by a programmable number of readout rows. It reports line and row progress to the downstream capture logic, and reports frame completion and abort to the control register block.

---
 rtl/roic_line_seq_if.sv | 28 ++
 rtl/roic_line_seq.sv | 107 ++++++++++
 tb/tb_roic_line_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/roic_line_seq_if.sv
// roic_line_seq_if: start/config inputs and line/row progress outputs of the ROIC line sequencer.
interface roic_line_seq_if #(
   parameter int TLINE_CNTR_W = 14,
   parameter int ROW_CNTR_W   = 12,
   parameter int DUMMY_CNTR_W = 4
);
   logic                    start;
   logic                    abort;
   logic [TLINE_CNTR_W-1:0] tline_reg;
   logic [ROW_CNTR_W-1:0]   row_num;
   logic [DUMMY_CNTR_W-1:0] dummy_num;
   logic                    sync_trigger;
   logic                    busy;
   logic                    dummy_line;
   logic                    row_valid;
   logic [ROW_CNTR_W-1:0]   row_idx;
   logic                    frame_done;
   logic                    aborted;
   logic                    cfg_err;
   modport master (
      output start, abort, tline_reg, row_num, dummy_num,
      input  sync_trigger, busy, dummy_line, row_valid, row_idx, frame_done, aborted, cfg_err
   );
   modport slave (
      input  start, abort, tline_reg, row_num, dummy_num,
      output sync_trigger, busy, dummy_line, row_valid, row_idx, frame_done, aborted, cfg_err
   );
endinterface

// File: rtl/roic_line_seq.sv
// roic_line_seq: frame sequencer emitting one sync_trigger per line over dummy lines then readout rows.
module roic_line_seq #(
   parameter int TLINE_CNTR_W = 14,
   parameter int ROW_CNTR_W   = 12,
   parameter int DUMMY_CNTR_W = 4,
   parameter int TLINE_MIN    = 16
) (
   input logic mclk,
   input logic rst,
   roic_line_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DUMMY, ROWS, FIN} state_t;
   localparam logic [TLINE_CNTR_W-1:0] TMIN = TLINE_CNTR_W'(TLINE_MIN);
   state_t                  state_q;
   logic [TLINE_CNTR_W-1:0] tline_q, tcnt_q;
   logic [ROW_CNTR_W-1:0]   rows_q, row_idx_q;
   logic [DUMMY_CNTR_W-1:0] dummy_q, dcnt_q;
   logic                    sync_q, busy_q, dline_q, rvalid_q, done_q, abort_q, cfg_err_q;
   assign bus.sync_trigger = sync_q;
   assign bus.busy         = busy_q;
   assign bus.dummy_line   = dline_q;
   assign bus.row_valid    = rvalid_q;
   assign bus.row_idx      = row_idx_q;
   assign bus.frame_done   = done_q;
   assign bus.aborted      = abort_q;
   assign bus.cfg_err      = cfg_err_q;
   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q   <= IDLE;
         tline_q   <= '0;
         tcnt_q    <= '0;
         rows_q    <= '0;
         row_idx_q <= '0;
         dummy_q   <= '0;
         dcnt_q    <= '0;
         sync_q    <= 1'b0;
         busy_q    <= 1'b0;
         dline_q   <= 1'b0;
         rvalid_q  <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         sync_q    <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
         cfg_err_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.start) begin
               if (bus.tline_reg < TMIN) cfg_err_q <= 1'b1;
               else begin
                  tline_q   <= bus.tline_reg;
                  rows_q    <= bus.row_num;
                  dummy_q   <= bus.dummy_num;
                  tcnt_q    <= '0;
                  dcnt_q    <= '0;
                  row_idx_q <= '0;
                  if (bus.dummy_num != '0) begin
                     state_q <= DUMMY;
                     busy_q  <= 1'b1;
                     sync_q  <= 1'b1;
                     dline_q <= 1'b1;
                  end else if (bus.row_num != '0) begin
                     state_q  <= ROWS;
                     busy_q   <= 1'b1;
                     sync_q   <= 1'b1;
                     rvalid_q <= 1'b1;
                  end else begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end
               end
            end
            DUMMY, ROWS: if (bus.abort) begin
               state_q  <= IDLE;
               busy_q   <= 1'b0;
               dline_q  <= 1'b0;
               rvalid_q <= 1'b0;
               abort_q  <= 1'b1;
            end else if (tcnt_q != tline_q - 1'b1) tcnt_q <= tcnt_q + 1'b1;
            else begin
               // last cycle of a line: decide what the next line is
               tcnt_q <= '0;
               if (state_q == DUMMY && dcnt_q != dummy_q - 1'b1) begin
                  dcnt_q <= dcnt_q + 1'b1;
                  sync_q <= 1'b1;
               end else if (state_q == DUMMY && rows_q != '0) begin
                  state_q  <= ROWS;
                  sync_q   <= 1'b1;
                  dline_q  <= 1'b0;
                  rvalid_q <= 1'b1;
               end else if (state_q == ROWS && row_idx_q != rows_q - 1'b1) begin
                  row_idx_q <= row_idx_q + 1'b1;
                  sync_q    <= 1'b1;
               end else begin
                  state_q  <= FIN;
                  busy_q   <= 1'b0;
                  dline_q  <= 1'b0;
                  rvalid_q <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_roic_line_seq.sv
// tb_roic_line_seq: directed frames with a scoreboard of expected trigger and frame_done cycles.
module tb_roic_line_seq;
   typedef struct {int cyc; logic dl; logic rv; int ridx;} trig_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int dl_cnt, rv_cnt, busy_cnt, ab_cnt;
   trig_t tq[$];
   int fq[$];
   roic_line_seq_if bus ();
   roic_line_seq dut (.mclk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic step();
      trig_t e;
      @(negedge clk);
      if (bus.sync_trigger) begin
         chk("trig_expected", tq.size() != 0, 1);
         if (tq.size() != 0) begin
            e = tq.pop_front();
            chk("trig_cyc", cyc, e.cyc);
            chk("trig_dummy_line", bus.dummy_line, e.dl);
            chk("trig_row_valid", bus.row_valid, e.rv);
            chk("trig_row_idx", bus.row_idx, e.ridx);
         end
      end
      if (bus.frame_done) begin
         chk("done_expected", fq.size() != 0, 1);
         chk("done_busy", bus.busy, 0);
         if (fq.size() != 0) chk("done_cyc", cyc, fq.pop_front());
      end
      dl_cnt   += int'(bus.dummy_line);
      rv_cnt   += int'(bus.row_valid);
      busy_cnt += int'(bus.busy);
      ab_cnt   += int'(bus.aborted);
   endtask
   task automatic clr();
      dl_cnt = 0;
      rv_cnt = 0;
      busy_cnt = 0;
      ab_cnt = 0;
   endtask
   task automatic push_frame(int s, int t, int d, int r, int keep);
      int n = 0;
      for (int i = 0; i < d; i++) begin
         if (keep < 0 || n < keep) tq.push_back('{s + n * t, 1'b1, 1'b0, 0});
         n++;
      end
      for (int j = 0; j < r; j++) begin
         if (keep < 0 || n < keep) tq.push_back('{s + n * t, 1'b0, 1'b1, j});
         n++;
      end
      if (keep < 0) fq.push_back(s + (d + r) * t);
   endtask
   task automatic go(int t, int d, int r, bit ok, int keep);
      bus.tline_reg = 14'(t);
      bus.dummy_num = 4'(d);
      bus.row_num   = 12'(r);
      bus.start     = 1'b1;
      if (ok) push_frame(cyc + 1, t, d, r, keep);
      step();
      bus.start = 1'b0;
   endtask
   task automatic drained(string tag);
      chk({tag, "_trig_left"}, tq.size(), 0);
      chk({tag, "_done_left"}, fq.size(), 0);
   endtask
   initial begin
      int s;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.tline_reg = '0;
      bus.dummy_num = '0;
      bus.row_num = '0;
      clr();
      repeat (2) step();
      chk("rst_sync", bus.sync_trigger, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_row_idx", bus.row_idx, 0);
      chk("rst_pulses", {bus.frame_done, bus.aborted, bus.cfg_err, bus.dummy_line, bus.row_valid}, 0);
      rst = 1'b0;
      step();
      // 2 dummy + 3 rows at 20 cycles per line
      clr();
      go(20, 2, 3, 1, -1);
      chk("f1_first_busy", bus.busy, 1);
      repeat (105) step();
      chk("f1_dummy_cycles", dl_cnt, 40);
      chk("f1_row_cycles", rv_cnt, 60);
      chk("f1_busy_cycles", busy_cnt, 100);
      drained("f1");
      // line time below minimum is rejected, then minimum is accepted
      clr();
      go(10, 0, 1, 0, -1);
      chk("cfg_err_pulse", bus.cfg_err, 1);
      chk("cfg_err_busy", bus.busy, 0);
      step();
      chk("cfg_err_one_cycle", bus.cfg_err, 0);
      repeat (20) step();
      chk("cfg_err_busy_cycles", busy_cnt, 0);
      go(16, 0, 1, 1, -1);
      repeat (20) step();
      drained("tmin");
      // empty frame, then dummy-only frame
      clr();
      go(16, 0, 0, 1, -1);
      chk("empty_busy", bus.busy, 0);
      repeat (3) step();
      chk("empty_busy_cycles", busy_cnt, 0);
      go(16, 1, 0, 1, -1);
      repeat (20) step();
      chk("dummy_only_dl", dl_cnt, 16);
      chk("dummy_only_rv", rv_cnt, 0);
      drained("small");
      // restart attempt while busy, then abort in row 2 cycle 5
      clr();
      go(20, 0, 4, 1, 3);
      s = cyc;
      repeat (21) step();
      bus.tline_reg = 14'd30;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("busy_start_no_cfg_err", bus.cfg_err, 0);
      while (cyc < s + 45) step();
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_pulse", bus.aborted, 1);
      chk("abort_busy", bus.busy, 0);
      chk("abort_row_valid", bus.row_valid, 0);
      repeat (60) step();
      chk("abort_count", ab_cnt, 1);
      drained("abort");
      // start held high across two frames
      clr();
      bus.tline_reg = 14'd16;
      bus.dummy_num = 4'd0;
      bus.row_num = 12'd2;
      s = cyc + 1;
      push_frame(s, 16, 0, 2, -1);
      push_frame(s + 34, 16, 0, 2, -1);
      bus.start = 1'b1;
      for (int i = 0; i < 72; i++) begin
         step();
         if (cyc == s + 33) chk("gap_idle", {bus.busy, bus.frame_done, bus.sync_trigger}, 0);
         if (cyc == s + 40) bus.start = 1'b0;
      end
      bus.start = 1'b0;
      drained("b2b");
      // reset in row 3 of an 8-row frame, then a full frame
      clr();
      go(16, 0, 8, 1, 4);
      s = cyc;
      while (cyc < s + 50) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_row_idx", bus.row_idx, 0);
      chk("mid_rst_pulses", {bus.sync_trigger, bus.frame_done, bus.aborted, bus.cfg_err, bus.dummy_line, bus.row_valid}, 0);
      step();
      clr();
      go(16, 0, 8, 1, -1);
      repeat (135) step();
      chk("post_rst_rows", rv_cnt, 128);
      chk("post_rst_abort", ab_cnt, 0);
      drained("post_rst");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
